// File: rtl/alu_pkg.sv
// ALU opcode encodes, dispatcher state encoding and opcode classification shared by the ALU and its dispatcher.
// Pure declarations and combinational helpers: no latency, no backpressure.
package alu_pkg;

  localparam int ALU_ADD        = 0;
  localparam int ALU_SUB        = 1;
  localparam int ALU_AND        = 2;
  localparam int ALU_OR         = 3;
  localparam int ALU_XOR        = 4;
  localparam int ALU_SLT        = 5;
  localparam int ALU_SLTU       = 6;
  localparam int ALU_SRA        = 7;
  localparam int ALU_MUL        = 8;
  localparam int ALU_DIV        = 9;
  localparam int ALU_SLL        = 10;
  localparam int ALU_SRL        = 11;
  localparam int HIGHEST_ENCODE = 12;

  typedef enum logic [1:0] {
    OP_SINGLE,
    OP_MULTI,
    OP_REJECT
  } op_class_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COMB,
    S_SEQ_PULSE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_WB
  } disp_state_e;

  // DIV has no datapath behind the dispatcher, so it is rejected alongside unused encodes.
  function automatic op_class_e classify_op(input logic [31:0] op);
    if (op >= HIGHEST_ENCODE) return OP_REJECT;
    if (op < ALU_MUL)         return OP_SINGLE;
    if (op == ALU_MUL || op == ALU_SLL || op == ALU_SRL) return OP_MULTI;
    return OP_REJECT;
  endfunction

endpackage

// File: rtl/alu_dispatch_wb_reg.sv
// Writeback holding register: loads rd/data/invalid and presents them with wb_valid until wb_ready.
// Latency 1 cycle from load; wb_ready low holds every output stable indefinitely.
module alu_dispatch_wb_reg #(
  parameter int DATA_WIDTH = 64,
  parameter int RD_WIDTH   = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [RD_WIDTH-1:0]   load_rd,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_invalid,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [RD_WIDTH-1:0]   wb_rd,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic                  wb_invalid
);

  // The dispatcher only loads while the register is empty, so load never races a pending handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid   <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
      wb_invalid <= 1'b0;
    end else if (load) begin
      wb_valid   <= 1'b1;
      wb_rd      <= load_rd;
      wb_data    <= load_data;
      wb_invalid <= load_invalid;
    end else if (wb_valid && wb_ready) begin
      wb_valid   <= 1'b0;
      wb_invalid <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_dispatcher.sv
// Issue-side ALU controller (ALU_DISPATCH_TIMEOUT_EN adds a done-timeout and sticky timeout_flag); one request in flight.
// Latency: 2 cycles request->wb_valid for 1-cycle ops, ALU-dependent for multi-cycle; req_ready low until the writeback handshake.
module alu_dispatcher
  import alu_pkg::*;
#(
  parameter int OPERAND_WIDTH  = 64,
  parameter int OPCODE_WIDTH   = 4,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int BUSY_WAIT_MAX  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [OPCODE_WIDTH-1:0]   req_op,
  input  logic [OPERAND_WIDTH-1:0]  req_a,
  input  logic [OPERAND_WIDTH-1:0]  req_b,
  input  logic [REG_ADDR_WIDTH-1:0] req_rd,
  output logic [OPERAND_WIDTH-1:0]  alu_operand_1,
  output logic [OPERAND_WIDTH-1:0]  alu_operand_2,
  output logic [OPCODE_WIDTH-1:0]   alu_op_code,
  output logic                      alu_enable_comb,
  output logic                      alu_enable_seq,
  input  logic                      alu_idle,
  input  logic [OPERAND_WIDTH-1:0]  alu_result_1cycle,
  input  logic [OPERAND_WIDTH-1:0]  alu_result_multi,
  output logic                      wb_valid,
  input  logic                      wb_ready,
  output logic [REG_ADDR_WIDTH-1:0] wb_rd,
  output logic [OPERAND_WIDTH-1:0]  wb_data,
`ifdef ALU_DISPATCH_TIMEOUT_EN
  output logic                      timeout_flag,
`endif
  output logic                      wb_invalid
);

  typedef struct packed {
    logic [OPCODE_WIDTH-1:0]   op;
    logic [OPERAND_WIDTH-1:0]  a;
    logic [OPERAND_WIDTH-1:0]  b;
    logic [REG_ADDR_WIDTH-1:0] rd;
  } req_t;

  localparam int BW = $clog2(BUSY_WAIT_MAX + 1);

  disp_state_e               state;
  req_t                      req_q;
  logic [BW-1:0]             busy_cnt;
  logic                      accept;
  op_class_e                 req_class;
  logic                      wb_load;
  logic                      wb_load_invalid;
  logic [OPERAND_WIDTH-1:0]  wb_load_data;
  logic [REG_ADDR_WIDTH-1:0] wb_load_rd;
`ifdef ALU_DISPATCH_TIMEOUT_EN
  logic [15:0]               done_cnt;
`endif

  assign accept        = req_valid && req_ready;
  assign req_class     = classify_op(32'(req_op));
  assign alu_operand_1 = req_q.a;
  assign alu_operand_2 = req_q.b;
  assign alu_op_code   = req_q.op;

  // Rejected ops load the writeback straight from the request, before the latch has captured it.
  always_comb begin
    wb_load         = 1'b0;
    wb_load_invalid = 1'b0;
    wb_load_data    = '0;
    wb_load_rd      = (state == S_IDLE) ? req_rd : req_q.rd;
    case (state)
      S_IDLE: begin
        if (accept && req_class == OP_REJECT) begin
          wb_load         = 1'b1;
          wb_load_invalid = 1'b1;
        end
      end
      S_COMB: begin
        wb_load      = 1'b1;
        wb_load_data = alu_result_1cycle;
      end
      S_WAIT_BUSY: begin
        // Idle never dropped: the ALU finished within a cycle of the start pulse.
        if (alu_idle && busy_cnt == BW'(BUSY_WAIT_MAX - 1)) begin
          wb_load      = 1'b1;
          wb_load_data = alu_result_multi;
        end
      end
      S_WAIT_DONE: begin
        if (alu_idle) begin
          wb_load      = 1'b1;
          wb_load_data = alu_result_multi;
        end
`ifdef ALU_DISPATCH_TIMEOUT_EN
        else if (done_cnt == 16'hFFFF) begin
          wb_load         = 1'b1;
          wb_load_invalid = 1'b1;
        end
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      req_ready       <= 1'b0;
      req_q           <= '0;
      alu_enable_comb <= 1'b0;
      alu_enable_seq  <= 1'b0;
      busy_cnt        <= '0;
`ifdef ALU_DISPATCH_TIMEOUT_EN
      done_cnt        <= '0;
      timeout_flag    <= 1'b0;
`endif
    end else begin
      alu_enable_comb <= 1'b0;
      alu_enable_seq  <= 1'b0;
      case (state)
        S_IDLE: begin
          req_ready <= !accept;
          if (accept) begin
            req_q.op <= req_op;
            req_q.a  <= req_a;
            req_q.b  <= req_b;
            req_q.rd <= req_rd;
            case (req_class)
              OP_SINGLE: begin
                state           <= S_COMB;
                alu_enable_comb <= 1'b1;
              end
              OP_MULTI: state <= S_SEQ_PULSE;
              default:  state <= S_WB;
            endcase
          end
        end
        S_COMB: state <= S_WB;
        S_SEQ_PULSE: begin
          if (alu_idle) begin
            alu_enable_seq <= 1'b1;
            busy_cnt       <= '0;
            state          <= S_WAIT_BUSY;
          end
        end
        S_WAIT_BUSY: begin
          if (!alu_idle) begin
            state <= S_WAIT_DONE;
`ifdef ALU_DISPATCH_TIMEOUT_EN
            done_cnt <= '0;
`endif
          end else if (wb_load) begin
            state <= S_WB;
          end else begin
            busy_cnt <= busy_cnt + 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (wb_load) begin
            state <= S_WB;
`ifdef ALU_DISPATCH_TIMEOUT_EN
            if (!alu_idle) timeout_flag <= 1'b1;
`endif
          end
`ifdef ALU_DISPATCH_TIMEOUT_EN
          else begin
            done_cnt <= done_cnt + 16'd1;
          end
`endif
        end
        S_WB: begin
          if (wb_valid && wb_ready) begin
            state     <= S_IDLE;
            req_ready <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  alu_dispatch_wb_reg #(
    .DATA_WIDTH (OPERAND_WIDTH),
    .RD_WIDTH   (REG_ADDR_WIDTH)
  ) u_wb_reg (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (wb_load),
    .load_rd      (wb_load_rd),
    .load_data    (wb_load_data),
    .load_invalid (wb_load_invalid),
    .wb_valid     (wb_valid),
    .wb_ready     (wb_ready),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .wb_invalid   (wb_invalid)
  );

endmodule

// File: tb/tb_alu_dispatcher.sv
// Scoreboard bench for alu_dispatcher with a behavioural ALU whose multi-cycle latency and idle line are controllable.
module tb_alu_dispatcher;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [3:0]  req_op;
  logic [63:0] req_a, req_b;
  logic [4:0]  req_rd;
  logic [63:0] alu_operand_1, alu_operand_2;
  logic [3:0]  alu_op_code;
  logic        alu_enable_comb, alu_enable_seq, alu_idle;
  logic [63:0] alu_result_1cycle, alu_result_multi;
  logic        wb_valid, wb_ready, wb_invalid;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
`ifdef ALU_DISPATCH_TIMEOUT_EN
  logic        timeout_flag;
`endif

  always #5 clk = ~clk;

  alu_dispatcher dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_rd(req_rd),
    .alu_operand_1(alu_operand_1), .alu_operand_2(alu_operand_2), .alu_op_code(alu_op_code),
    .alu_enable_comb(alu_enable_comb), .alu_enable_seq(alu_enable_seq), .alu_idle(alu_idle),
    .alu_result_1cycle(alu_result_1cycle), .alu_result_multi(alu_result_multi),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
`ifdef ALU_DISPATCH_TIMEOUT_EN
    .timeout_flag(timeout_flag),
`endif
    .wb_invalid(wb_invalid)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference ALU: bit 64 flags an encode the dispatcher must reject.
  function automatic logic [64:0] ref_alu(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [64:0] r;
    r = '0;
    case (int'(op))
      ALU_ADD:  r[63:0] = a + b;
      ALU_SUB:  r[63:0] = a - b;
      ALU_AND:  r[63:0] = a & b;
      ALU_OR:   r[63:0] = a | b;
      ALU_XOR:  r[63:0] = a ^ b;
      ALU_SLT:  r[63:0] = {63'd0, $signed(a) < $signed(b)};
      ALU_SLTU: r[63:0] = {63'd0, a < b};
      ALU_SRA:  r[63:0] = $signed(a) >>> b[5:0];
      ALU_MUL:  r[63:0] = a * b;
      ALU_SLL:  r[63:0] = a << b[5:0];
      ALU_SRL:  r[63:0] = a >> b[5:0];
      default:  r[64] = 1'b1;
    endcase
    return r;
  endfunction

  // Behavioural ALU
  int          mc_lat;
  int          mc_cnt;
  logic        mc_busy, ext_busy, stuck;
  logic [63:0] mc_res;
  logic [64:0] alu_f;

  assign alu_f             = ref_alu(alu_op_code, alu_operand_1, alu_operand_2);
  assign alu_idle          = !mc_busy && !ext_busy;
  assign alu_result_1cycle = (alu_enable_comb && alu_op_code < 4'd8) ? alu_f[63:0] : 64'd0;
  assign alu_result_multi  = mc_busy ? 64'hBAD0_BAD0_BAD0_BAD0 : mc_res;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mc_busy <= 1'b0;
      mc_cnt  <= 0;
      mc_res  <= '0;
    end else if (alu_enable_seq) begin
      mc_res <= alu_f[63:0];
      if (mc_lat > 0) begin
        mc_busy <= 1'b1;
        mc_cnt  <= mc_lat;
      end
    end else if (mc_busy && !stuck) begin
      if (mc_cnt <= 1) mc_busy <= 1'b0;
      else mc_cnt <= mc_cnt - 1;
    end
  end

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
    logic        inv;
  } exp_t;
  exp_t sb[$];

  int   comb_cnt = 0;
  int   seq_cnt  = 0;
  logic seq_prev = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      check_eq("enable_exclusive", 64'(alu_enable_comb & alu_enable_seq), 64'd0);
      check_eq("seq_back_to_back", 64'(alu_enable_seq & seq_prev), 64'd0);
      check_eq("ready_vs_wb", 64'(req_ready & wb_valid), 64'd0);
      comb_cnt += int'(alu_enable_comb);
      seq_cnt  += int'(alu_enable_seq);
      if (wb_valid && wb_ready) begin
        check_eq("wb_expected", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          check_eq("sb_rd", 64'(wb_rd), 64'(e.rd));
          check_eq("sb_data", wb_data, e.data);
          check_eq("sb_invalid", 64'(wb_invalid), 64'(e.inv));
        end
      end
    end
    seq_prev = alu_enable_seq & rst_n;
  end

  task automatic send(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd);
    logic [64:0] m;
    exp_t        e;
    int          n;
    n = 0;
    req_valid = 1'b1;
    req_op = op; req_a = a; req_b = b; req_rd = rd;
    @(negedge clk);
    while (!req_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_eq("send_accept", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    m = ref_alu(op, a, b);
    e.rd = rd; e.data = m[63:0]; e.inv = m[64];
    sb.push_back(e);
  endtask

  task automatic wait_wb(input string tag, input int budget);
    int   n;
    logic seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < budget) begin
      @(negedge clk);
      n++;
      if (wb_valid && wb_ready) seen = 1'b1;
      else check_eq({tag, "_ready_low"}, 64'(req_ready), 64'd0);
    end
    check_eq({tag, "_wb_seen"}, 64'(seen), 64'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, s0, n;
    logic [3:0] rop;
    rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; req_rd = '0;
    wb_ready = 1'b1; ext_busy = 1'b0; stuck = 1'b0; mc_lat = 5;

    #12;
    check_eq("rst_req_ready", 64'(req_ready), 64'd0);
    check_eq("rst_en_comb", 64'(alu_enable_comb), 64'd0);
    check_eq("rst_en_seq", 64'(alu_enable_seq), 64'd0);
    check_eq("rst_opnd1", alu_operand_1, 64'd0);
    check_eq("rst_opcode", 64'(alu_op_code), 64'd0);
    check_eq("rst_wb_valid", 64'(wb_valid), 64'd0);
    check_eq("rst_wb_data", wb_data, 64'd0);
    check_eq("rst_wb_invalid", 64'(wb_invalid), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("idle_req_ready", 64'(req_ready), 64'd1);
    @(posedge clk); #1;

    // ADD: enable_comb for one cycle, wb_valid two cycles after the request
    c0 = comb_cnt;
    send(4'(ALU_ADD), 64'd5, 64'd7, 5'd3);
    @(negedge clk);
    check_eq("add_comb_en", 64'(alu_enable_comb), 64'd1);
    check_eq("add_wb_early", 64'(wb_valid), 64'd0);
    @(negedge clk);
    check_eq("add_wb_valid", 64'(wb_valid), 64'd1);
    check_eq("add_wb_rd", 64'(wb_rd), 64'd3);
    check_eq("add_wb_data", wb_data, 64'd12);
    check_eq("add_wb_invalid", 64'(wb_invalid), 64'd0);
    @(posedge clk); #1;
    check_eq("add_comb_cycles", 64'(comb_cnt - c0), 64'd1);

    // MUL with the ALU busy for 5 cycles
    s0 = seq_cnt; c0 = comb_cnt; mc_lat = 5;
    send(4'(ALU_MUL), 64'd6, 64'd7, 5'd8);
    wait_wb("mul", 40);
    check_eq("mul_seq_pulses", 64'(seq_cnt - s0), 64'd1);
    check_eq("mul_comb_pulses", 64'(comb_cnt - c0), 64'd0);

    // Rejected encodes never touch the ALU
    s0 = seq_cnt; c0 = comb_cnt;
    send(4'(ALU_DIV), 64'd10, 64'd2, 5'd4);
    wait_wb("div", 10);
    send(4'd13, 64'd1, 64'd1, 5'd5);
    wait_wb("op13", 10);
    check_eq("rej_alu_activity", 64'((seq_cnt - s0) + (comb_cnt - c0)), 64'd0);

    // Writeback stall holds outputs and blocks new requests
    wb_ready = 1'b0; mc_lat = 2;
    send(4'(ALU_SLL), 64'd1, 64'd4, 5'd10);
    n = 0;
    while (!wb_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    check_eq("stall_wb_valid", 64'(wb_valid), 64'd1);
    req_valid = 1'b1; req_op = 4'(ALU_ADD); req_a = 64'd100; req_b = 64'd1; req_rd = 5'd11;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("stall_valid_held", 64'(wb_valid), 64'd1);
      check_eq("stall_data_held", wb_data, 64'd16);
      check_eq("stall_rd_held", 64'(wb_rd), 64'd10);
      check_eq("stall_no_accept", 64'(req_ready), 64'd0);
    end
    @(posedge clk); #1 wb_ready = 1'b1;
    wait_wb("stall_release", 5);
    send(4'(ALU_ADD), 64'd100, 64'd1, 5'd11);
    wait_wb("post_stall_add", 10);

    // ALU finishes without ever dropping idle: bounded busy-wait completes the op
    mc_lat = 0;
    send(4'(ALU_SRL), 64'd256, 64'd3, 5'd12);
    wait_wb("srl_fast", 20);

    // ALU busy before issue: no start pulse until idle
    ext_busy = 1'b1; mc_lat = 3; s0 = seq_cnt;
    send(4'(ALU_MUL), 64'd3, 64'd9, 5'd13);
    repeat (6) @(negedge clk);
    check_eq("pre_no_pulse", 64'(seq_cnt - s0), 64'd0);
    @(posedge clk); #1 ext_busy = 1'b0;
    wait_wb("pre_mul", 30);
    check_eq("pre_one_pulse", 64'(seq_cnt - s0), 64'd1);

    // A handful of 1-cycle ops with random operands
    for (int i = 0; i < 6; i++) begin
      rop = 4'($urandom_range(0, 7));
      send(rop, {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom_range(0, 31)));
      wait_wb("rand_single", 10);
    end

    // Reset while waiting on a long SRL
    mc_lat = 20;
    send(4'(ALU_SRL), 64'd256, 64'd3, 5'd7);
    repeat (6) @(negedge clk);
    check_eq("rst_mid_alu_busy", 64'(alu_idle), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_mid_req_ready", 64'(req_ready), 64'd0);
    check_eq("rst_mid_opnd1", alu_operand_1, 64'd0);
    check_eq("rst_mid_opnd2", alu_operand_2, 64'd0);
    check_eq("rst_mid_opcode", 64'(alu_op_code), 64'd0);
    check_eq("rst_mid_en", 64'({alu_enable_comb, alu_enable_seq}), 64'd0);
    check_eq("rst_mid_wb", 64'({wb_valid, wb_invalid, wb_rd}), 64'd0);
    check_eq("rst_mid_wb_data", wb_data, 64'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      check_eq("rst_no_wb", 64'(wb_valid), 64'd0);
    end
    @(posedge clk); #1;

`ifdef ALU_DISPATCH_TIMEOUT_EN
    begin
      exp_t e;
      check_eq("tmo_flag_clear", 64'(timeout_flag), 64'd0);
      stuck = 1'b1; mc_lat = 5;
      send(4'(ALU_MUL), 64'd6, 64'd7, 5'd9);
      void'(sb.pop_back());
      e.rd = 5'd9; e.data = 64'd0; e.inv = 1'b1;
      sb.push_back(e);
      wait_wb("tmo", 70000);
      check_eq("tmo_flag_set", 64'(timeout_flag), 64'd1);
      stuck = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check_eq("tmo_flag_sticky", 64'(timeout_flag), 64'd1);
    end
`endif

    check_eq("sb_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
